// File: rtl/vend_pkg.sv
// Shared definitions for the coin acceptor and the vending FSM that consumes its coin codes.
// Holds coin codes, the acceptor state encoding and the default width windows.
package vend_pkg;

    localparam logic [1:0] COIN_NONE = 2'd0;
    localparam logic [1:0] COIN_ONE  = 2'd1;
    localparam logic [1:0] COIN_TWO  = 2'd2;

    typedef enum logic [1:0] {
        ACC_IDLE     = 2'd0,
        ACC_MEASURE  = 2'd1,
        ACC_CLASSIFY = 2'd2,
        ACC_FAULT    = 2'd3
    } acc_state_t;

    localparam int DEF_DEB    = 3;
    localparam int DEF_W1_MIN = 8;
    localparam int DEF_W1_MAX = 15;
    localparam int DEF_W2_MIN = 20;
    localparam int DEF_W2_MAX = 31;
    localparam int DEF_STUCK  = 63;
    localparam int DEF_CW     = 6;

    // Maps a measured width onto a coin code; COIN_NONE means the width is outside both windows.
    function automatic logic [1:0] width_to_coin(
        input int unsigned width,
        input int unsigned w1_min,
        input int unsigned w1_max,
        input int unsigned w2_min,
        input int unsigned w2_max
    );
        logic [1:0] code;
        code = COIN_NONE;
        if (width >= w1_min && width <= w1_max) begin
            code = COIN_ONE;
        end else if (width >= w2_min && width <= w2_max) begin
            code = COIN_TWO;
        end
        return code;
    endfunction

endpackage

// File: rtl/coin_sync_debounce.sv
// Purpose: two-flop synchroniser on the raw coin sense line, then a DEB-cycle stability filter.
// Latency: 2 + DEB edges from raw change to q_filt change, identical for rise and fall.
// Backpressure: none; free-running filter, glitches shorter than DEB cycles are dropped.
module coin_sync_debounce
    import vend_pkg::*;
#(
    parameter int DEB = DEF_DEB
) (
    input  logic clk,
    input  logic rst,
    input  logic d_raw,
    output logic q_filt
);

    localparam int DW = (DEB > 1) ? $clog2(DEB) : 1;

    logic          r_s1;
    logic          r_s2;
    logic          r_filt;
    logic [DW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_filt <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_s1 <= d_raw;
            r_s2 <= r_s1;
            // Counter holds the number of consecutive disagreeing edges seen so far.
            if (r_s2 == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == DW'(DEB - 1)) begin
                r_filt <= r_s2;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign q_filt = r_filt;

endmodule

// File: rtl/coin_acceptor.sv
// Purpose: classify debounced coin pulses by width into one-cycle coin/rej outputs; latch a jam fault.
// Latency: coin/rej appear DEB+3 edges after sense_raw is first sampled low.
// Backpressure: none; accept_en low turns would-be coins into rejects, sampled only at classification.
module coin_acceptor
    import vend_pkg::*;
#(
    parameter int DEB    = DEF_DEB,
    parameter int W1_MIN = DEF_W1_MIN,
    parameter int W1_MAX = DEF_W1_MAX,
    parameter int W2_MIN = DEF_W2_MIN,
    parameter int W2_MAX = DEF_W2_MAX,
    parameter int STUCK  = DEF_STUCK,
    parameter int CW     = DEF_CW
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sense_raw,
    input  logic       accept_en,
    output logic [1:0] coin,
    output logic       rej,
    output logic       fault,
    output logic       busy
);

    localparam logic [CW-1:0] STUCK_C = CW'(STUCK);

    logic          w_filt;
    acc_state_t    r_state;
    acc_state_t    w_state_nxt;
    logic [CW-1:0] r_wcnt;
    logic [CW-1:0] w_wcnt_nxt;
    logic [1:0]    r_coin;
    logic [1:0]    w_coin_nxt;
    logic          r_rej;
    logic          w_rej_nxt;
    logic          r_fault;
    logic          w_fault_nxt;
    logic [1:0]    w_code;

    coin_sync_debounce #(
        .DEB (DEB)
    ) u_sync_debounce (
        .clk    (clk),
        .rst    (rst),
        .d_raw  (sense_raw),
        .q_filt (w_filt)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ACC_IDLE;
            r_wcnt  <= '0;
            r_coin  <= COIN_NONE;
            r_rej   <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
            r_coin  <= w_coin_nxt;
            r_rej   <= w_rej_nxt;
            r_fault <= w_fault_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        w_coin_nxt  = COIN_NONE;
        w_rej_nxt   = 1'b0;
        w_fault_nxt = r_fault;
        w_code      = COIN_NONE;

        case (r_state)
            ACC_IDLE: begin
                w_wcnt_nxt = '0;
                if (w_filt) begin
                    w_state_nxt = ACC_MEASURE;
                    w_wcnt_nxt  = CW'(1);
                end
            end
            ACC_MEASURE: begin
                if (w_filt) begin
                    // Saturate at STUCK and latch the jam instead of ever wrapping.
                    if (r_wcnt >= STUCK_C - 1'b1) begin
                        w_wcnt_nxt  = STUCK_C;
                        w_state_nxt = ACC_FAULT;
                        w_fault_nxt = 1'b1;
                    end else begin
                        w_wcnt_nxt = r_wcnt + 1'b1;
                    end
                end else begin
                    w_state_nxt = ACC_CLASSIFY;
                end
            end
            ACC_CLASSIFY: begin
                w_code = width_to_coin(32'(r_wcnt), W1_MIN, W1_MAX, W2_MIN, W2_MAX);
                if (accept_en && (w_code != COIN_NONE)) begin
                    w_coin_nxt = w_code;
                end else begin
                    w_rej_nxt = 1'b1;
                end
                // A new debounced rise landing here starts the next measurement without loss.
                if (w_filt) begin
                    w_state_nxt = ACC_MEASURE;
                    w_wcnt_nxt  = CW'(1);
                end else begin
                    w_state_nxt = ACC_IDLE;
                    w_wcnt_nxt  = '0;
                end
            end
            ACC_FAULT: begin
                w_fault_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = ACC_IDLE;
                w_wcnt_nxt  = '0;
            end
        endcase
    end

    assign coin  = r_coin;
    assign rej   = r_rej;
    assign fault = r_fault;
    assign busy  = (r_state == ACC_MEASURE) || (r_state == ACC_CLASSIFY);

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: pulse-level reference model predicts each coin/rej event and its cycle.
// Observed nonzero output cycles are recorded and compared per scenario.
module tb_coin_acceptor;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sense_raw = 1'b0;
    logic       accept_en = 1'b0;
    logic [1:0] coin;
    logic       rej;
    logic       fault;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit m_fault = 1'b0;

    typedef struct {
        int         t;
        logic [1:0] c;
        logic       r;
    } ev_t;

    ev_t obs_q[$];
    ev_t exp_q[$];

    always #5 clk = ~clk;

    coin_acceptor dut (
        .clk       (clk),
        .rst       (rst),
        .sense_raw (sense_raw),
        .accept_en (accept_en),
        .coin      (coin),
        .rej       (rej),
        .fault     (fault),
        .busy      (busy)
    );

    // Record every cycle in which any output event is visible.
    initial begin
        ev_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (coin !== 2'd0 || rej !== 1'b0) begin
                e.t = cyc;
                e.c = coin;
                e.r = rej;
                obs_q.push_back(e);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1);
    end

    // Pulse-level reference: a raw pulse of n cycles is a coin of width n if it survives debounce.
    function automatic void model(input int n, input bit acc, output bit has,
                                  output logic [1:0] c, output logic r);
        has = 1'b0;
        c   = 2'd0;
        r   = 1'b0;
        if (m_fault || n < 3) return;
        if (n >= 63) begin
            m_fault = 1'b1;
            return;
        end
        has = 1'b1;
        if (acc && n >= 8 && n <= 15)       c = 2'd1;
        else if (acc && n >= 20 && n <= 31) c = 2'd2;
        else                                r = 1'b1;
    endfunction

    function automatic string ev_dump(input ev_t q[$]);
        string s;
        s = "";
        foreach (q[i]) s = {s, $sformatf("%0d:%0d/%0d ", q[i].t, q[i].c, q[i].r)};
        if (q.size() == 0) s = "none";
        return s;
    endfunction

    // Called at a negedge; returns at the negedge where sense_raw is dropped.
    task automatic drive_pulse(input int n, input bit acc, input bit wiggle);
        bit         has;
        logic [1:0] c;
        logic       r;
        ev_t        e;
        sense_raw = 1'b1;
        accept_en = wiggle ? ~acc : acc;
        repeat (n) @(negedge clk);
        sense_raw = 1'b0;
        accept_en = acc;
        model(n, acc, has, c, r);
        if (has) begin
            e.t = cyc + 7;
            e.c = c;
            e.r = r;
            exp_q.push_back(e);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (coin !== 2'd0) begin bad++; $display("FAIL reset_coin: got %0d want 0", coin); end
        total++; if (rej !== 1'b0) begin bad++; $display("FAIL reset_rej: got %0b want 0", rej); end
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault: got %0b want 0", fault); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
        rst = 1'b1;
        repeat (4) @(negedge clk);
        obs_q.delete();
    endtask

    task automatic test_one_unit();
        drive_pulse(10, 1'b1, 1'b0);
        repeat (12) @(negedge clk);
        total++;
        if (ev_dump(obs_q) != ev_dump(exp_q)) begin
            bad++; $display("FAIL one_unit: got %s want %s", ev_dump(obs_q), ev_dump(exp_q));
        end
        obs_q.delete(); exp_q.delete();
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL one_unit_fault: got %0b want 0", fault); end
    endtask

    task automatic test_back_to_back();
        drive_pulse(25, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        drive_pulse(12, 1'b1, 1'b0);
        repeat (12) @(negedge clk);
        total++;
        if (ev_dump(obs_q) != ev_dump(exp_q)) begin
            bad++; $display("FAIL back_to_back: got %s want %s", ev_dump(obs_q), ev_dump(exp_q));
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reject_widths();
        drive_pulse(17, 1'b1, 1'b0);
        repeat (8) @(negedge clk);
        drive_pulse(5, 1'b1, 1'b0);
        repeat (8) @(negedge clk);
        drive_pulse(40, 1'b1, 1'b0);
        repeat (12) @(negedge clk);
        total++;
        if (ev_dump(obs_q) != ev_dump(exp_q)) begin
            bad++; $display("FAIL reject_widths: got %s want %s", ev_dump(obs_q), ev_dump(exp_q));
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_glitch_and_disable();
        bit busy_seen;
        busy_seen = 1'b0;
        drive_pulse(2, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) busy_seen = 1'b1;
        end
        total++; if (busy_seen !== 1'b0) begin bad++; $display("FAIL glitch_busy: got 1 want 0"); end
        drive_pulse(10, 1'b0, 1'b0);
        repeat (12) @(negedge clk);
        total++;
        if (ev_dump(obs_q) != ev_dump(exp_q)) begin
            bad++; $display("FAIL glitch_disable: got %s want %s", ev_dump(obs_q), ev_dump(exp_q));
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_accept_sampling();
        drive_pulse(10, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        drive_pulse(22, 1'b0, 1'b1);
        repeat (12) @(negedge clk);
        total++;
        if (ev_dump(obs_q) != ev_dump(exp_q)) begin
            bad++; $display("FAIL accept_sampling: got %s want %s", ev_dump(obs_q), ev_dump(exp_q));
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_fault();
        bit         has;
        logic [1:0] c;
        logic       r;
        sense_raw = 1'b1;
        accept_en = 1'b1;
        repeat (30) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL fault_busy_mid: got %0b want 1", busy); end
        repeat (40) @(negedge clk);
        sense_raw = 1'b0;
        model(70, 1'b1, has, c, r);
        repeat (10) @(negedge clk);
        total++; if (fault !== m_fault) begin bad++; $display("FAIL fault_set: got %0b want %0b", fault, m_fault); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL fault_busy: got %0b want 0", busy); end
        drive_pulse(10, 1'b1, 1'b0);
        repeat (12) @(negedge clk);
        total++;
        if (ev_dump(obs_q) != ev_dump(exp_q)) begin
            bad++; $display("FAIL fault_quiet: got %s want %s", ev_dump(obs_q), ev_dump(exp_q));
        end
        obs_q.delete(); exp_q.delete();
        total++; if (fault !== 1'b1) begin bad++; $display("FAIL fault_sticky: got %0b want 1", fault); end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        m_fault = 1'b0;
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL fault_clear: got %0b want 0", fault); end
        drive_pulse(10, 1'b1, 1'b0);
        repeat (12) @(negedge clk);
        total++;
        if (ev_dump(obs_q) != ev_dump(exp_q)) begin
            bad++; $display("FAIL fault_recover: got %s want %s", ev_dump(obs_q), ev_dump(exp_q));
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid_measure();
        sense_raw = 1'b1;
        accept_en = 1'b1;
        repeat (17) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before: got %0b want 1", busy); end
        rst = 1'b0;
        sense_raw = 1'b0;
        @(negedge clk);
        total++;
        if ({coin, rej, fault, busy} !== 5'b0) begin
            bad++; $display("FAIL midrst_outputs: got coin=%0d rej=%0b fault=%0b busy=%0b want all 0", coin, rej, fault, busy);
        end
        rst = 1'b1;
        repeat (14) @(negedge clk);
        total++;
        if (ev_dump(obs_q) != ev_dump(exp_q)) begin
            bad++; $display("FAIL midrst_events: got %s want %s", ev_dump(obs_q), ev_dump(exp_q));
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        int n;
        bit acc;
        for (int k = 0; k < 12; k++) begin
            n   = $urandom_range(1, 35);
            acc = ($urandom_range(0, 3) != 0);
            drive_pulse(n, acc, $urandom_range(0, 1) == 1);
            repeat ($urandom_range(10, 14)) @(negedge clk);
            total++;
            if (ev_dump(obs_q) != ev_dump(exp_q)) begin
                bad++; $display("FAIL random_%0d n=%0d acc=%0b: got %s want %s", k, n, acc, ev_dump(obs_q), ev_dump(exp_q));
            end
            obs_q.delete(); exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_one_unit();
        test_back_to_back();
        test_reject_widths();
        test_glitch_and_disable();
        test_accept_sampling();
        test_random();
        test_fault();
        test_reset_mid_measure();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
